sata_tx_cont_align: RTL and testbench
=====================================

SATA_TX_CONT_ALIGN -- requirements
Module: sata_tx_cont_align

Interface
REQ-001 SHALL have parameter ALIGN_INTERVAL, default 256: output dwords per ALIGN period, including the ALIGN pair; legal values are even, 8..1024.
REQ-002 SHALL have parameter CONT_EN_DEFAULT, default 1: CONT suppression enable used while the cont_en port is tied high.
REQ-003 SHALL run on one clock, clk; reset is synchronous and active-low, port rst_n.
REQ-004 SHALL have ports, as name  direction  width  meaning:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- phy_ready  in  1  PHY link up.
- align_en  in  1  enables periodic ALIGN insertion.
- cont_en  in  1  enables CONT/junk suppression (ANDed with CONT_EN_DEFAULT).
- in_dout  in  32  dword from link write/read layer.
- in_isk  in  1  in_dout is a primitive (K28.x in byte 0).
- in_ready  out  1  dword accepted this cycle; drives link layer phy_ready.
- phy_tx_dout  out  32  dword to PHY.
- phy_tx_isk  out  4  K flags to PHY.
- align_count  out  11  current position within ALIGN period (debug).

Function
REQ-005 SHALL define ALIGN = 32'h7B4A4ABC and CONT = 32'h9999AA7C; primitive outputs carry phy_tx_isk = 4'b0001, data and junk outputs 4'b0000.
REQ-006 SHALL register phy_tx_dout/phy_tx_isk: the dword accepted in cycle N appears in cycle N+1 (latency 1).
REQ-007 SHALL drive in_ready = rst_n && phy_ready && !align_slot (combinational); upstream holds in_dout while in_ready is low.
REQ-008 SHALL, while phy_ready = 0, output ALIGN every cycle, hold align_count at 0, and clear the CONT state to PASS.
REQ-009 SHALL increment align_count by 1 on every output cycle while phy_ready = 1 and align_en = 1, wrapping ALIGN_INTERVAL-1 -> 0.
REQ-010 SHALL set align_slot when align_count is ALIGN_INTERVAL-2 or ALIGN_INTERVAL-1, output ALIGN in both cycles, and accept no input in those cycles.
REQ-011 SHALL, while align_en = 0, hold align_count at 0 and never insert ALIGN.
REQ-012 SHALL implement the CONT FSM with states PASS, SECOND, CONT, JUNK, tracking last_prim (32 bits) = the last accepted primitive.
REQ-013 Repeat: an accepted dword that is a primitive, equals last_prim, and is neither ALIGN nor CONT.
REQ-014 PASS: output input as-is; on a repeat -> SECOND.
REQ-015 SECOND: output input as-is (second copy); on a repeat -> CONT.
REQ-016 CONT: output CONT; on a repeat -> JUNK.
REQ-017 JUNK: output junk data, isk 4'b0000; stay in JUNK while repeats continue.
REQ-018 SHALL, when any non-repeat dword is accepted in any state, output it unchanged, load last_prim (or clear it for data), and go to PASS.
REQ-019 SHALL generate junk from a 32-bit LFSR (x^32+x^22+x^2+x+1), seed 32'hFFFFFFFF, advanced only on junk output cycles.
REQ-020 SHALL clear last_prim and force PASS after every ALIGN pair, so a continuing primitive is re-sent twice before CONT resumes.
REQ-021 SHALL, when cont_en && CONT_EN_DEFAULT = 0, stay in PASS and pass all dwords through unchanged.
REQ-022 SHALL pass incoming ALIGN and CONT dwords through unchanged, without affecting last_prim.
REQ-023 SHALL give precedence phy_ready = 0 > align_slot > CONT FSM when these occur in the same cycle.

Reset
REQ-024 While rst_n = 0 on a clk edge, SHALL set phy_tx_dout = ALIGN, phy_tx_isk = 4'b0001, align_count = 0, state = PASS, last_prim = 0, LFSR = 32'hFFFFFFFF.
REQ-025 SHALL hold in_ready = 0 during reset.
REQ-026 Reset mid-stream SHALL discard all CONT and ALIGN progress; the first dword accepted after release is passed unchanged.

Verification
REQ-027 Scenario — reset then phy_ready = 1, align_en = 0, data 0x00000001..0x00000010: the same 16 dwords appear on phy_tx_dout one cycle later, isk 0, in_ready constantly 1.
REQ-028 Scenario — 6 consecutive SYNC (0xB5B5957C, isk = 1): output SYNC, SYNC, CONT, then 3 junk dwords; first junk = LFSR step 1 from seed; an X_RDY after them is passed unchanged.
REQ-029 Scenario — align_en = 1, ALIGN_INTERVAL = 8, continuous data: ALIGN appears at output slots 6, 7, 14, 15; in_ready is low exactly in those slots; no data dword is lost or duplicated.
REQ-030 Scenario — HOLD repeated across an ALIGN pair: output HOLD, HOLD, CONT, junk, ALIGN, ALIGN, HOLD, HOLD, CONT, junk.
REQ-031 Scenario — phy_ready dropped for 3 cycles mid-JUNK: 3 ALIGNs output, in_ready = 0, align_count = 0; after recovery the repeated primitive is output twice again.
REQ-032 Scenario — rst_n low for 1 cycle during state CONT: next outputs ALIGN/isk 0001, state PASS, LFSR reseeded to 32'hFFFFFFFF.

Source files
------------

// File: rtl/sata_tx_cont_align.sv
// sata_tx_cont_align
// Transmit-side primitive shaper between the SATA link layer and the PHY.
// Inserts an ALIGN pair every ALIGN_INTERVAL output dwords and replaces long
// runs of a repeated primitive with the sequence prim, prim, CONT, then
// scrambled junk until the run ends.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   phy_ready    PHY link up; while low only ALIGN is sent
//   align_en     enables periodic ALIGN insertion
//   cont_en      enables CONT/junk suppression (ANDed with CONT_EN_DEFAULT)
//   in_dout      dword from the link layer
//   in_isk       in_dout is a primitive (K28.x in byte 0)
//   in_ready     dword accepted this cycle (combinational)
//   phy_tx_dout  registered dword to the PHY
//   phy_tx_isk   registered K flags to the PHY
//   align_count  position within the ALIGN period (debug)
module sata_tx_cont_align #(
  parameter int unsigned ALIGN_INTERVAL  = 256,
  parameter bit          CONT_EN_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phy_ready,
  input  logic        align_en,
  input  logic        cont_en,
  input  logic [31:0] in_dout,
  input  logic        in_isk,
  output logic        in_ready,
  output logic [31:0] phy_tx_dout,
  output logic [3:0]  phy_tx_isk,
  output logic [10:0] align_count
);

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] PRIM_CONT  = 32'h9999_AA7C;
  localparam logic [31:0] LFSR_SEED  = 32'hFFFF_FFFF;
  localparam logic [10:0] SLOT_FIRST = 11'(ALIGN_INTERVAL - 2);
  localparam logic [10:0] SLOT_LAST  = 11'(ALIGN_INTERVAL - 1);

  typedef enum logic [1:0] {
    ST_PASS,
    ST_SECOND,
    ST_CONT,
    ST_JUNK
  } cont_state_e;

  cont_state_e state_q, state_d;
  logic [31:0] last_prim_q, last_prim_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] dout_q, dout_d;
  logic [3:0]  isk_q, isk_d;
  logic [10:0] count_q, count_d;

  logic align_slot;
  logic cont_on;
  logic is_ctrl_prim;
  logic is_repeat;

  // Fibonacci LFSR, taps for x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  always_comb begin
    align_slot   = align_en && phy_ready &&
                   ((count_q == SLOT_FIRST) || (count_q == SLOT_LAST));
    in_ready     = rst_n && phy_ready && !align_slot;
    cont_on      = cont_en && CONT_EN_DEFAULT;
    // ALIGN and CONT arriving from upstream are forwarded and never counted
    // as part of a repeat run.
    is_ctrl_prim = in_isk && ((in_dout == PRIM_ALIGN) || (in_dout == PRIM_CONT));
    is_repeat    = in_isk && !is_ctrl_prim && (in_dout == last_prim_q);

    state_d     = state_q;
    last_prim_d = last_prim_q;
    lfsr_d      = lfsr_q;
    dout_d      = PRIM_ALIGN;
    isk_d       = 4'b0001;
    count_d     = count_q;

    if (!phy_ready) begin
      count_d     = '0;
      state_d     = ST_PASS;
      last_prim_d = '0;
    end else begin
      if (!align_en) begin
        count_d = '0;
      end else if (count_q == SLOT_LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + 11'd1;
      end

      if (align_slot) begin
        // Forgetting the primitive here makes a continuing run restart with
        // two literal copies after the ALIGN pair.
        state_d     = ST_PASS;
        last_prim_d = '0;
      end else begin
        dout_d = in_dout;
        isk_d  = in_isk ? 4'b0001 : 4'b0000;
        if (!cont_on) begin
          state_d     = ST_PASS;
          last_prim_d = '0;
        end else if (is_ctrl_prim) begin
          state_d = state_q;
        end else if (!is_repeat) begin
          state_d     = ST_PASS;
          last_prim_d = in_isk ? in_dout : '0;
        end else begin
          // The state reached on a repeat names what is sent for it.
          unique case (state_q)
            ST_PASS: begin
              state_d = ST_SECOND;
            end
            ST_SECOND: begin
              state_d = ST_CONT;
              dout_d  = PRIM_CONT;
              isk_d   = 4'b0001;
            end
            ST_CONT, ST_JUNK: begin
              state_d = ST_JUNK;
              lfsr_d  = lfsr_step(lfsr_q);
              dout_d  = lfsr_step(lfsr_q);
              isk_d   = 4'b0000;
            end
            default: begin
              state_d = ST_PASS;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_PASS;
      last_prim_q <= '0;
      lfsr_q      <= LFSR_SEED;
      dout_q      <= PRIM_ALIGN;
      isk_q       <= 4'b0001;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_prim_q <= last_prim_d;
      lfsr_q      <= lfsr_d;
      dout_q      <= dout_d;
      isk_q       <= isk_d;
      count_q     <= count_d;
    end
  end

  assign phy_tx_dout = dout_q;
  assign phy_tx_isk  = isk_q;
  assign align_count = count_q;

endmodule

// File: tb/tb_sata_tx_cont_align.sv
module tb_sata_tx_cont_align;

  localparam int unsigned INTERVAL = 8;
  localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] CONT  = 32'h9999_AA7C;
  localparam logic [31:0] SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] HOLDA = 32'h9595_AA7C;
  localparam logic [31:0] R_RDY = 32'h4A4A_957C;
  localparam logic [31:0] X_RDY = 32'h5757_B57C;

  logic        clk = 1'b0;
  logic        rst_n, phy_ready, align_en, cont_en, in_isk;
  logic [31:0] in_dout;
  logic        in_ready;
  logic [31:0] phy_tx_dout;
  logic [3:0]  phy_tx_isk;
  logic [10:0] align_count;

  always #5 clk = ~clk;

  sata_tx_cont_align #(
    .ALIGN_INTERVAL (INTERVAL),
    .CONT_EN_DEFAULT(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phy_ready  (phy_ready),
    .align_en   (align_en),
    .cont_en    (cont_en),
    .in_dout    (in_dout),
    .in_isk     (in_isk),
    .in_ready   (in_ready),
    .phy_tx_dout(phy_tx_dout),
    .phy_tx_isk (phy_tx_isk),
    .align_count(align_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the ALIGN period as a plain integer and the
  // length of the current repeat run; the run length decides the output.
  int          m_pos = 0;
  int          m_run = 0;
  logic [31:0] m_last = '0;
  logic [31:0] m_lfsr = 32'hFFFF_FFFF;
  logic [31:0] e_dout;
  logic [3:0]  e_isk;
  logic        e_ready;
  logic [31:0] obs[$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  task automatic model_step();
    logic slot;
    e_dout  = ALIGN;
    e_isk   = 4'b0001;
    e_ready = 1'b0;
    if (!rst_n) begin
      m_pos = 0; m_run = 0; m_last = '0; m_lfsr = 32'hFFFF_FFFF;
    end else if (!phy_ready) begin
      m_pos = 0; m_run = 0; m_last = '0;
    end else begin
      slot    = align_en && (m_pos >= int'(INTERVAL) - 2);
      e_ready = !slot;
      m_pos   = align_en ? (m_pos + 1) % int'(INTERVAL) : 0;
      if (slot) begin
        m_run = 0; m_last = '0;
      end else begin
        e_dout = in_dout;
        e_isk  = in_isk ? 4'b0001 : 4'b0000;
        if (!cont_en) begin
          m_run = 0; m_last = '0;
        end else if (in_isk && (in_dout == ALIGN || in_dout == CONT)) begin
          // forwarded, run untouched
        end else if (in_isk && in_dout == m_last) begin
          m_run++;
          if (m_run == 2) begin
            e_dout = CONT;
          end else if (m_run >= 3) begin
            m_lfsr = lfsr_next(m_lfsr);
            e_dout = m_lfsr;
            e_isk  = 4'b0000;
          end
        end else begin
          m_run  = 0;
          m_last = in_isk ? in_dout : '0;
        end
      end
    end
  endtask

  // Inputs are already applied; check in_ready, clock once, check outputs.
  task automatic step();
    #1;
    model_step();
    check("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
    @(posedge clk);
    #1;
    check("phy_tx_dout", phy_tx_dout, e_dout);
    check("phy_tx_isk", {28'b0, phy_tx_isk}, {28'b0, e_isk});
    check("align_count", {21'b0, align_count}, m_pos);
    obs.push_back(phy_tx_dout);
  endtask

  task automatic send(input logic [31:0] d, input logic k);
    in_dout = d;
    in_isk  = k;
    step();
  endtask

  task automatic do_reset(input logic ae);
    rst_n = 1'b0; phy_ready = 1'b1; align_en = ae; cont_en = 1'b1;
    in_dout = '0; in_isk = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    obs.delete();
  endtask

  logic [31:0] nxt;
  logic [31:0] prim_tab[7];
  logic        prev_k;
  logic [31:0] prev_d;

  initial begin
    prim_tab[0] = SYNC;  prim_tab[1] = HOLD;  prim_tab[2] = HOLDA;
    prim_tab[3] = R_RDY; prim_tab[4] = X_RDY; prim_tab[5] = ALIGN;
    prim_tab[6] = CONT;

    // Plain data with ALIGN disabled: straight pass-through.
    do_reset(1'b0);
    check("reset_dout", phy_tx_dout, ALIGN);
    check("reset_isk", {28'b0, phy_tx_isk}, 32'h1);
    for (int i = 1; i <= 16; i++) send(32'(i), 1'b0);
    for (int i = 0; i < 16; i++) check("data_pass", obs[i], 32'(i + 1));

    // Six SYNCs then X_RDY.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) send(SYNC, 1'b1);
    send(X_RDY, 1'b1);
    check("sync0", obs[0], SYNC);
    check("sync1", obs[1], SYNC);
    check("sync_cont", obs[2], CONT);
    check("junk1", obs[3], 32'hFFFF_FFFE);
    check("junk2", obs[4], 32'hFFFF_FFFD);
    check("junk3", obs[5], 32'hFFFF_FFFB);
    check("xrdy", obs[6], X_RDY);

    // Continuous data with ALIGN every 8 dwords; nothing lost or duplicated.
    do_reset(1'b1);
    nxt = 32'h100;
    for (int c = 0; c < 24; c++) begin
      in_dout = nxt; in_isk = 1'b0;
      step();
      if (e_ready) nxt++;
      if (c % 8 >= 6) check("align_slot", phy_tx_dout, ALIGN);
    end
    begin
      logic [31:0] want;
      want = 32'h100;
      foreach (obs[i]) if (obs[i] != ALIGN) begin
        check("no_loss", obs[i], want);
        want++;
      end
      check("data_count", want, nxt);
    end

    // HOLD run straddling an ALIGN pair.
    do_reset(1'b1);
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    obs.delete();
    for (int i = 0; i < 10; i++) send(HOLD, 1'b1);
    check("ha0", obs[0], HOLD);
    check("ha1", obs[1], HOLD);
    check("ha2", obs[2], CONT);
    check("ha3", obs[3], 32'hFFFF_FFFE);
    check("ha4", obs[4], ALIGN);
    check("ha5", obs[5], ALIGN);
    check("ha6", obs[6], HOLD);
    check("ha7", obs[7], HOLD);
    check("ha8", obs[8], CONT);

    // PHY drop for three cycles inside JUNK.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) send(HOLD, 1'b1);
    phy_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(HOLD, 1'b1);
    phy_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(HOLD, 1'b1);
    check("drop_align", obs[5], ALIGN);
    check("drop_align3", obs[7], ALIGN);
    check("recov0", obs[8], HOLD);
    check("recov1", obs[9], HOLD);
    check("recov2", obs[10], CONT);

    // One-cycle reset while in CONT.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) send(HOLD, 1'b1);
    rst_n = 1'b0;
    send(HOLD, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(HOLD, 1'b1);
    check("rst_align", obs[3], ALIGN);
    check("rst_pass0", obs[4], HOLD);
    check("rst_pass1", obs[5], HOLD);
    check("rst_cont", obs[6], CONT);
    check("rst_seed", obs[7], 32'hFFFF_FFFE);

    // Randomized traffic against the model.
    do_reset(1'b1);
    prev_k = 1'b0; prev_d = '0; e_ready = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (phy_ready) phy_ready = ($urandom_range(0, 39) != 0);
      else           phy_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) align_en = ~align_en;
      if ($urandom_range(0, 149) == 0) cont_en = ~cont_en;
      if (e_ready) begin
        if (prev_k && $urandom_range(0, 9) < 7) begin
          in_dout = prev_d; in_isk = 1'b1;
        end else if ($urandom_range(0, 9) < 4) begin
          in_dout = $urandom; in_isk = 1'b0;
        end else begin
          in_dout = prim_tab[$urandom_range(0, 6)]; in_isk = 1'b1;
        end
      end
      prev_d = in_dout; prev_k = in_isk;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
